// File: rtl/ixc_mc_ofifo_tx_if.sv
// Beat-side and host-side handshake bundle for ixc_mc_ofifo_tx.
// slave: the FIFO (takes oData* beats, drives tx*); master: its environment.
interface ixc_mc_ofifo_tx_if #(
    parameter int TID_W = 16
);
    logic             oDataEn;
    logic [511:0]     oData;
    logic [3:0]       oDataLen;
    logic             oSt;
    logic [15:0]      oPktLen;
    logic [TID_W-1:0] oTid;
    logic [11:0]      oDly;
    logic             oReady;
    logic             txValid;
    logic             txReady;
    logic [255:0]     txData;
    logic [2:0]       txWords;
    logic             txLast;

    modport master (
        output oDataEn, oData, oDataLen, oSt, oPktLen, oTid, oDly,
        input  oReady,
        input  txValid, txData, txWords, txLast,
        output txReady
    );

    modport slave (
        input  oDataEn, oData, oDataLen, oSt, oPktLen, oTid, oDly,
        output oReady,
        output txValid, txData, txWords, txLast,
        input  txReady
    );
endinterface

// File: rtl/ixc_mc_ofifo_tx.sv
// Packet output FIFO: 512b DUT beats in (header prepended), 256b host beats out.
// Ports: fclk, hssResetN (async, low), b (slave: oData*/oReady, tx*),
//   ackClkX/ackLenX (packet-done toggle + length), errLen (sticky).
// Macro IXC_OFIFO_ODLY_EN: put oDly into header [59:48] (else zero).
module ixc_mc_ofifo_tx #(
    parameter int DEPTH_LOG2 = 6,
    parameter int TID_W      = 16
) (
    input  logic             fclk,
    input  logic             hssResetN,
    ixc_mc_ofifo_tx_if.slave b,
    output logic             ackClkX,
    output logic [17:0]      ackLenX,
    output logic             errLen
);
    localparam int PW = DEPTH_LOG2 + 1;
    localparam int AW = DEPTH_LOG2;

    typedef enum logic {S_IDLE, S_PKT} ist_t;

    logic [63:0]    mem_q [1<<AW];
    logic           end_q [1<<AW];

    logic [PW-1:0]  wptr_q, rptr_q, fptr_q;
    logic [PW-1:0]  occ, avail;
    logic [PW:0]    free;
    ist_t           ist_q, ist_d;
    logic [15:0]    rem_q, rem_d;
    logic           first_q, err_q;

    logic           acc, err_set, close;
    logic [3:0]     len;
    logic [15:0]    len16, lim;
    logic [3:0]     use_n, nwr;
    logic [63:0]    hdr;
    logic [11:0]    dly;
    logic [TID_W-1:0] tid_w;
    logic [15:0]    tid16;
    logic [63:0]    wd [9];
    logic           we [9];
    logic [AW-1:0]  wa [9];

    logic [AW-1:0]  ra [4];
    logic [63:0]    rwd [4];
    logic           re [4];
    logic [2:0]     f_n;
    logic           f_last;
    logic [255:0]   f_data;
    logic           ld, hs;

    logic           txValid_q, txLast_q, ackClk_q;
    logic [255:0]   txData_q;
    logic [2:0]     txWords_q;
    logic [17:0]    ackLen_q, rdcnt_q;

    assign occ      = wptr_q - rptr_q;
    assign avail    = wptr_q - fptr_q;
    assign free     = (PW+1)'(1 << AW) - {1'b0, occ};
    assign b.oReady = hssResetN && (free >= (PW+1)'(9));

    assign acc   = b.oDataEn && b.oReady;
    assign len   = (b.oDataLen > 4'd8) ? 4'd8 : b.oDataLen;
    assign len16 = {12'd0, len};
    assign tid_w = b.oTid;
    assign tid16 = 16'(tid_w);

`ifdef IXC_OFIFO_ODLY_EN
    assign dly = b.oDly;
`else
    logic unused_dly;
    assign dly        = 12'h000;
    assign unused_dly = ^b.oDly;
`endif

    assign hdr = {1'b1, 1'b0, first_q, 1'b0, dly, b.oPktLen, tid16,
                  12'd0, b.oDataLen};

    // Words kept from this beat: capped by the packet's remaining length.
    assign lim   = b.oSt ? b.oPktLen : rem_q;
    assign use_n = (lim < len16) ? lim[3:0] : len;

    always_ff @(posedge fclk or negedge hssResetN) begin
        if (!hssResetN) begin
            ist_q   <= S_IDLE;
            rem_q   <= '0;
            wptr_q  <= '0;
            first_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            ist_q  <= ist_d;
            rem_q  <= rem_d;
            wptr_q <= wptr_q + PW'(nwr);
            if (acc && b.oSt) first_q <= 1'b0;
            if (err_set) err_q <= 1'b1;
        end
    end

    always_comb begin
        ist_d   = ist_q;
        rem_d   = rem_q;
        err_set = 1'b0;
        close   = 1'b0;
        if (acc) begin
            if (b.oSt) begin
                close   = (ist_q == S_PKT);
                err_set = (ist_q == S_PKT) || (b.oPktLen < len16);
                if (b.oPktLen <= len16) begin
                    ist_d = S_IDLE;
                    rem_d = '0;
                end else begin
                    ist_d = S_PKT;
                    rem_d = b.oPktLen - len16;
                end
            end else if (ist_q == S_IDLE) begin
                err_set = 1'b1;
            end else if (rem_q <= len16) begin
                ist_d   = S_IDLE;
                rem_d   = '0;
                err_set = (rem_q < len16);
            end else begin
                rem_d = rem_q - len16;
            end
        end
    end

    always_comb begin
        nwr = '0;
        for (int i = 0; i < 9; i++) begin
            wd[i] = '0;
            we[i] = 1'b0;
            wa[i] = AW'(wptr_q + PW'(i));
        end
        if (acc && b.oSt) begin
            nwr   = use_n + 4'd1;
            wd[0] = hdr;
            for (int k = 0; k < 8; k++) wd[k+1] = b.oData[64*k +: 64];
            we[use_n] = (ist_d == S_IDLE);
        end else if (acc && ist_q == S_PKT) begin
            nwr = use_n;
            for (int k = 0; k < 8; k++) wd[k] = b.oData[64*k +: 64];
            if (ist_d == S_IDLE && use_n != 4'd0) we[use_n - 4'd1] = 1'b1;
        end
    end

    // Storage needs no reset: pointers bound what is valid.
    // A close marks the newest word, which the fetch never takes early.
    always_ff @(posedge fclk) begin
        if (close) end_q[AW'(wptr_q - PW'(1))] <= 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (4'(i) < nwr) begin
                mem_q[wa[i]] <= wd[i];
                end_q[wa[i]] <= we[i];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            ra[k]  = AW'(fptr_q + PW'(k));
            rwd[k] = mem_q[ra[k]];
            re[k]  = end_q[ra[k]] && (PW'(k) < avail);
        end
    end

    // While a packet is still arriving, keep its newest word back so a
    // mismatch close can still mark it as the packet end.
    always_comb begin
        f_n    = '0;
        f_last = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!f_last && re[k]) begin
                f_last = 1'b1;
                f_n    = 3'(k + 1);
            end
        end
        if (!f_last && avail >= PW'(4) &&
            (ist_q == S_IDLE || avail >= PW'(5)))
            f_n = 3'd4;
        f_data = '0;
        for (int k = 0; k < 4; k++)
            if (3'(k) < f_n) f_data[64*k +: 64] = rwd[k];
    end

    assign ld = !txValid_q || b.txReady;
    assign hs = txValid_q && b.txReady;

    always_ff @(posedge fclk or negedge hssResetN) begin
        if (!hssResetN) begin
            fptr_q    <= '0;
            rptr_q    <= '0;
            txValid_q <= 1'b0;
            txData_q  <= '0;
            txWords_q <= '0;
            txLast_q  <= 1'b0;
            ackClk_q  <= 1'b0;
            ackLen_q  <= '0;
            rdcnt_q   <= '0;
        end else begin
            if (hs) begin
                rptr_q <= rptr_q + PW'(txWords_q);
                if (txLast_q) begin
                    ackClk_q <= ~ackClk_q;
                    ackLen_q <= rdcnt_q + 18'(txWords_q);
                    rdcnt_q  <= '0;
                end else begin
                    rdcnt_q <= rdcnt_q + 18'(txWords_q);
                end
            end
            if (ld) begin
                txValid_q <= (f_n != 3'd0);
                if (f_n != 3'd0) begin
                    txData_q  <= f_data;
                    txWords_q <= f_n;
                    txLast_q  <= f_last;
                    fptr_q    <= fptr_q + PW'(f_n);
                end
            end
        end
    end

    assign b.txValid = txValid_q;
    assign b.txData  = txData_q;
    assign b.txWords = txWords_q;
    assign b.txLast  = txLast_q;
    assign ackClkX   = ackClk_q;
    assign ackLenX   = ackLen_q;
    assign errLen    = err_q;
endmodule

// File: tb/tb_ixc_mc_ofifo_tx.sv
// Directed bench for ixc_mc_ofifo_tx.
// Beats are recorded by a monitor; each test task checks its own results.
module tb_ixc_mc_ofifo_tx;
    logic        fclk = 1'b0;
    logic        hssResetN;
    logic        ackClkX;
    logic [17:0] ackLenX;
    logic        errLen;

`ifdef IXC_OFIFO_ODLY_EN
    localparam bit DLY_ON = 1'b1;
`else
    localparam bit DLY_ON = 1'b0;
`endif

    ixc_mc_ofifo_tx_if #(.TID_W(16)) bif ();

    ixc_mc_ofifo_tx #(.DEPTH_LOG2(6), .TID_W(16)) dut (
        .fclk      (fclk),
        .hssResetN (hssResetN),
        .b         (bif),
        .ackClkX   (ackClkX),
        .ackLenX   (ackLenX),
        .errLen    (errLen)
    );

    always #5 fclk = ~fclk;

    int n_chk = 0;
    int n_fail = 0;
    logic [255:0] q_data [$];
    logic [2:0]   q_words [$];
    logic         q_last [$];
    logic [17:0]  q_ack [$];
    logic         ack_prev = 1'b0;
    logic [63:0]  exp_w [$];
    logic [63:0]  got_w [$];

    always @(negedge fclk) begin
        if (bif.txValid && bif.txReady) begin
            q_data.push_back(bif.txData);
            q_words.push_back(bif.txWords);
            q_last.push_back(bif.txLast);
        end
        if (ackClkX !== ack_prev) q_ack.push_back(ackLenX);
        ack_prev = ackClkX;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    function automatic logic [63:0] wd(input int base, input int k);
        return 64'hD000_0000_0000_0000 | (64'(base) << 8) | 64'(k);
    endfunction

    function automatic logic [63:0] hdr(input logic [3:0] dl,
        input logic [15:0] tid, input logic [15:0] pl,
        input logic [11:0] dly, input logic rf);
        return {1'b1, 1'b0, rf, 1'b0, (DLY_ON ? dly : 12'h000),
                pl, tid, 12'h000, dl};
    endfunction

    task automatic clear_q();
        q_data.delete();
        q_words.delete();
        q_last.delete();
        q_ack.delete();
        exp_w.delete();
        got_w.delete();
    endtask

    task automatic collect();
        got_w.delete();
        foreach (q_data[i])
            for (int k = 0; k < int'(q_words[i]); k++)
                got_w.push_back(q_data[i][64*k +: 64]);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge fclk);
        #1;
    endtask

    task automatic set_beat(input bit st, input int dl, input int pl,
        input logic [15:0] tid, input logic [11:0] dly, input int base);
        bif.oDataEn  = 1'b1;
        bif.oSt      = st;
        bif.oDataLen = 4'(dl);
        bif.oPktLen  = 16'(pl);
        bif.oTid     = tid;
        bif.oDly     = dly;
        for (int k = 0; k < 8; k++) bif.oData[64*k +: 64] = wd(base, k);
    endtask

    task automatic beat(input bit st, input int dl, input int pl,
        input logic [15:0] tid, input logic [11:0] dly, input int base);
        int guard = 0;
        set_beat(st, dl, pl, tid, dly, base);
        while (!bif.oReady && guard < 200) begin
            @(posedge fclk);
            #1;
            guard++;
        end
        n_chk++;
        if (guard >= 200) begin
            n_fail++;
            $display("FAIL beat_ready_timeout got=oReady 0 exp=1");
        end
        @(posedge fclk);
        #1;
        bif.oDataEn = 1'b0;
        bif.oSt     = 1'b0;
    endtask

    task automatic cmp_stream(input string nm);
        collect();
        n_chk++;
        if (got_w.size() != exp_w.size()) begin
            n_fail++;
            $display("FAIL %s_count got=%0d exp=%0d", nm, got_w.size(),
                     exp_w.size());
        end
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
            n_chk++;
            if (got_w[i] !== exp_w[i]) begin
                n_fail++;
                $display("FAIL %s_word%0d got=%h exp=%h", nm, i, got_w[i],
                         exp_w[i]);
            end
        end
    endtask

    task automatic test_reset();
        hssResetN    = 1'b0;
        bif.txReady  = 1'b0;
        bif.oDataEn  = 1'b0;
        bif.oSt      = 1'b0;
        bif.oData    = '0;
        bif.oDataLen = '0;
        bif.oPktLen  = '0;
        bif.oTid     = '0;
        bif.oDly     = '0;
        cycles(3);
        n_chk++;
        if (bif.oReady !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_oready got=%b exp=0", bif.oReady);
        end
        n_chk++;
        if (bif.txValid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_txvalid got=%b exp=0", bif.txValid);
        end
        n_chk++;
        if ({ackClkX, ackLenX, errLen} !== 20'd0) begin
            n_fail++;
            $display("FAIL rst_ack got=%b/%0d/%b exp=0/0/0", ackClkX,
                     ackLenX, errLen);
        end
        hssResetN = 1'b1;
        cycles(1);
        n_chk++;
        if (bif.oReady !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_release_oready got=%b exp=1", bif.oReady);
        end
    endtask

    task automatic test_single();
        clear_q();
        bif.txReady = 1'b1;
        exp_w.push_back(hdr(4'd3, 16'h1234, 16'd3, 12'hABC, 1'b1));
        for (int k = 0; k < 3; k++) exp_w.push_back(wd(1, k));
        beat(1'b1, 3, 3, 16'h1234, 12'hABC, 1);
        cycles(20);
        n_chk++;
        if (q_data.size() != 1 || q_words[0] !== 3'd4 || q_last[0] !== 1'b1)
        begin
            n_fail++;
            $display("FAIL single_beat got=n%0d w%0d l%b exp=n1 w4 l1",
                     q_data.size(), q_words[0], q_last[0]);
        end
        n_chk++;
        if (q_data[0][61] !== 1'b1) begin
            n_fail++;
            $display("FAIL single_rstflag got=%b exp=1", q_data[0][61]);
        end
        n_chk++;
        if (q_data[0][59:48] !== (DLY_ON ? 12'hABC : 12'h000)) begin
            n_fail++;
            $display("FAIL single_odly got=%h exp=%h", q_data[0][59:48],
                     (DLY_ON ? 12'hABC : 12'h000));
        end
        cmp_stream("single");
        n_chk++;
        if (q_ack.size() != 1 || q_ack[0] !== 18'd4 || ackClkX !== 1'b1)
        begin
            n_fail++;
            $display("FAIL single_ack got=n%0d len%0d clk%b exp=n1 len4 clk1",
                     q_ack.size(), q_ack[0], ackClkX);
        end
        n_chk++;
        if (errLen !== 1'b0) begin
            n_fail++;
            $display("FAIL single_err got=%b exp=0", errLen);
        end
    endtask

    task automatic test_two_beat();
        logic [2:0] en [5] = '{3'd4, 3'd4, 3'd4, 3'd4, 3'd1};
        logic       el [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        clear_q();
        exp_w.push_back(hdr(4'd8, 16'h2222, 16'd16, 12'h123, 1'b0));
        for (int k = 0; k < 8; k++) exp_w.push_back(wd(2, k));
        for (int k = 0; k < 8; k++) exp_w.push_back(wd(3, k));
        beat(1'b1, 8, 16, 16'h2222, 12'h123, 2);
        beat(1'b0, 8, 16, 16'h2222, 12'h123, 3);
        cycles(30);
        n_chk++;
        if (q_data.size() != 5) begin
            n_fail++;
            $display("FAIL two_nbeats got=%0d exp=5", q_data.size());
        end
        for (int i = 0; i < 5 && i < q_data.size(); i++) begin
            n_chk++;
            if (q_words[i] !== en[i] || q_last[i] !== el[i]) begin
                n_fail++;
                $display("FAIL two_beat%0d got=w%0d l%b exp=w%0d l%b", i,
                         q_words[i], q_last[i], en[i], el[i]);
            end
        end
        n_chk++;
        if (q_data[4][255:64] !== 192'd0) begin
            n_fail++;
            $display("FAIL two_pad got=%h exp=0", q_data[4][255:64]);
        end
        cmp_stream("two");
        n_chk++;
        if (q_ack.size() != 1 || q_ack[0] !== 18'd17) begin
            n_fail++;
            $display("FAIL two_ack got=n%0d len%0d exp=n1 len17",
                     q_ack.size(), q_ack[0]);
        end
    endtask

    task automatic test_backpressure();
        int nacc = 0;
        clear_q();
        bif.txReady = 1'b0;
        for (int i = 0; i < 12; i++) begin
            set_beat(1'b1, 8, 8, 16'(16'h3300 + i), 12'h0F0, 10 + i);
            if (bif.oReady) begin
                nacc++;
                exp_w.push_back(hdr(4'd8, 16'(16'h3300 + i), 16'd8,
                                    12'h0F0, 1'b0));
                for (int k = 0; k < 8; k++) exp_w.push_back(wd(10 + i, k));
            end
            @(posedge fclk);
            #1;
        end
        bif.oDataEn = 1'b0;
        bif.oSt     = 1'b0;
        n_chk++;
        if (nacc != 7) begin
            n_fail++;
            $display("FAIL bp_accepted got=%0d exp=7", nacc);
        end
        n_chk++;
        if (bif.oReady !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_oready_full got=%b exp=0", bif.oReady);
        end
        n_chk++;
        if (bif.txValid !== 1'b1 || bif.txWords !== 3'd4) begin
            n_fail++;
            $display("FAIL bp_hold got=v%b w%0d exp=v1 w4", bif.txValid,
                     bif.txWords);
        end
        bif.txReady = 1'b1;
        cycles(60);
        n_chk++;
        if (q_data.size() != 21) begin
            n_fail++;
            $display("FAIL bp_nbeats got=%0d exp=21", q_data.size());
        end
        cmp_stream("bp");
        n_chk++;
        if (q_ack.size() != 7) begin
            n_fail++;
            $display("FAIL bp_nacks got=%0d exp=7", q_ack.size());
        end
        for (int i = 0; i < q_ack.size(); i++) begin
            n_chk++;
            if (q_ack[i] !== 18'd9) begin
                n_fail++;
                $display("FAIL bp_ack%0d got=%0d exp=9", i, q_ack[i]);
            end
        end
        n_chk++;
        if (bif.oReady !== 1'b1 || ackClkX !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_after got=r%b clk%b exp=r1 clk1", bif.oReady,
                     ackClkX);
        end
    endtask

    task automatic test_mismatch();
        logic [2:0] en [4] = '{3'd4, 3'd2, 3'd4, 3'd1};
        logic       el [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        clear_q();
        n_chk++;
        if (errLen !== 1'b0) begin
            n_fail++;
            $display("FAIL mis_err_before got=%b exp=0", errLen);
        end
        exp_w.push_back(hdr(4'd5, 16'hAAAA, 16'd10, 12'h111, 1'b0));
        for (int k = 0; k < 5; k++) exp_w.push_back(wd(20, k));
        exp_w.push_back(hdr(4'd4, 16'hBBBB, 16'd4, 12'h222, 1'b0));
        for (int k = 0; k < 4; k++) exp_w.push_back(wd(21, k));
        beat(1'b1, 5, 10, 16'hAAAA, 12'h111, 20);
        beat(1'b1, 4, 4, 16'hBBBB, 12'h222, 21);
        cycles(30);
        n_chk++;
        if (errLen !== 1'b1) begin
            n_fail++;
            $display("FAIL mis_err got=%b exp=1", errLen);
        end
        n_chk++;
        if (q_data.size() != 4) begin
            n_fail++;
            $display("FAIL mis_nbeats got=%0d exp=4", q_data.size());
        end
        for (int i = 0; i < 4 && i < q_data.size(); i++) begin
            n_chk++;
            if (q_words[i] !== en[i] || q_last[i] !== el[i]) begin
                n_fail++;
                $display("FAIL mis_beat%0d got=w%0d l%b exp=w%0d l%b", i,
                         q_words[i], q_last[i], en[i], el[i]);
            end
        end
        cmp_stream("mis");
        n_chk++;
        if (q_ack.size() != 2 || q_ack[0] !== 18'd6 || q_ack[1] !== 18'd5)
        begin
            n_fail++;
            $display("FAIL mis_ack got=n%0d %0d,%0d exp=n2 6,5",
                     q_ack.size(), q_ack[0], q_ack[1]);
        end
    endtask

    task automatic test_overrun();
        clear_q();
        exp_w.push_back(hdr(4'd8, 16'hCCCC, 16'd10, 12'h333, 1'b0));
        for (int k = 0; k < 8; k++) exp_w.push_back(wd(30, k));
        for (int k = 0; k < 2; k++) exp_w.push_back(wd(31, k));
        beat(1'b1, 8, 10, 16'hCCCC, 12'h333, 30);
        beat(1'b0, 8, 10, 16'hCCCC, 12'h333, 31);
        cycles(5);
        beat(1'b0, 3, 0, 16'hCCCC, 12'h333, 32);
        cycles(30);
        n_chk++;
        if (q_data.size() != 3 || q_words[2] !== 3'd3 || q_last[2] !== 1'b1)
        begin
            n_fail++;
            $display("FAIL ovr_beats got=n%0d w%0d l%b exp=n3 w3 l1",
                     q_data.size(), q_words[2], q_last[2]);
        end
        cmp_stream("ovr");
        n_chk++;
        if (q_ack.size() != 1 || q_ack[0] !== 18'd11) begin
            n_fail++;
            $display("FAIL ovr_ack got=n%0d len%0d exp=n1 len11",
                     q_ack.size(), q_ack[0]);
        end
    endtask

    task automatic test_reset_mid();
        clear_q();
        bif.txReady = 1'b0;
        beat(1'b1, 8, 40, 16'hDDDD, 12'h444, 40);
        for (int i = 1; i < 4; i++)
            beat(1'b0, 8, 40, 16'hDDDD, 12'h444, 40 + i);
        n_chk++;
        if (bif.oReady !== 1'b1 || bif.txValid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_prefill got=r%b v%b exp=r1 v1", bif.oReady,
                     bif.txValid);
        end
        hssResetN = 1'b0;
        #1;
        n_chk++;
        if (bif.oReady !== 1'b0 || bif.txValid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst_hs got=r%b v%b exp=r0 v0", bif.oReady,
                     bif.txValid);
        end
        n_chk++;
        if (bif.txData !== 256'd0 || bif.txWords !== 3'd0 ||
            bif.txLast !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst_tx got=w%0d l%b exp=w0 l0 data0",
                     bif.txWords, bif.txLast);
        end
        n_chk++;
        if ({ackClkX, ackLenX, errLen} !== 20'd0) begin
            n_fail++;
            $display("FAIL mid_rst_ack got=%b/%0d/%b exp=0/0/0", ackClkX,
                     ackLenX, errLen);
        end
        cycles(2);
        hssResetN = 1'b1;
        cycles(2);
        clear_q();
        bif.txReady = 1'b1;
        exp_w.push_back(hdr(4'd3, 16'hBEEF, 16'd3, 12'h5A5, 1'b1));
        for (int k = 0; k < 3; k++) exp_w.push_back(wd(50, k));
        beat(1'b1, 3, 3, 16'hBEEF, 12'h5A5, 50);
        cycles(20);
        n_chk++;
        if (q_data.size() != 1 || q_data[0][61] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_rstflag got=n%0d f%b exp=n1 f1",
                     q_data.size(), q_data[0][61]);
        end
        cmp_stream("mid");
        n_chk++;
        if (q_ack.size() != 1 || q_ack[0] !== 18'd4 || errLen !== 1'b0)
        begin
            n_fail++;
            $display("FAIL mid_ack got=n%0d len%0d e%b exp=n1 len4 e0",
                     q_ack.size(), q_ack[0], errLen);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_beat();
        test_backpressure();
        test_mismatch();
        test_overrun();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
